// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display scanner
// Purpose: FSM state encoding, active-low hex segment table, blank pattern.
// Ports: none (package).
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/disp_scan_if.sv
// rtl/disp_scan_if.sv - pooled-result input and 7-segment output bundle
// Purpose: groups the enable/data inputs and display outputs of disp_scan.
// Ports:
//   start    display enable level from the controller
//   val_flat NUM_VAL pooled results, value k at [k*DATA_W +: DATA_W]
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   dp       decimal point, active-low
//   an       anode enables, active-low, an[0] rightmost
//   shown    high while scanning
interface disp_scan_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_VAL = 4,
  parameter int NUM_DIG = 8
);
  logic                        start;
  logic [NUM_VAL*DATA_W-1:0]   val_flat;
  logic [6:0]                  seg;
  logic                        dp;
  logic [NUM_DIG-1:0]          an;
  logic                        shown;

  modport master (output start, output val_flat,
                  input seg, input dp, input an, input shown);
  modport slave  (input start, input val_flat,
                  output seg, output dp, output an, output shown);
endinterface

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low 7-segment decoder
// Purpose: table lookup of one hex digit.
// Ports:
//   nib  in  4  hex digit value
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - latches pooled results and multiplexes them onto a 7-segment display
// Purpose: on enable, capture NUM_VAL results once, then scan them as
//          NUM_DIG hex digits with a blank slot at the end of each digit.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of disp_scan_if (start, val_flat in; seg, dp, an, shown out)
module disp_scan
  import disp_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_VAL  = 4,
  parameter int NUM_DIG  = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  disp_scan_if.slave bus
);

  localparam int LAT_W       = NUM_VAL * DATA_W;
  localparam int DIV_W       = $clog2(SCAN_DIV);
  localparam int DIG_W       = $clog2(NUM_DIG);
  localparam int DIG_PER_VAL = DATA_W / 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIG - 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   latch_q, latch_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIG_W-1:0]   dig_q, dig_d;

  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [NUM_DIG-1:0] an_q, an_d;
  logic               shown_q, shown_d;

  logic [3:0]         nib_d;
  logic [6:0]         hex_seg;

  hex_to_seg u_hex (
    .nib (nib_d),
    .seg (hex_seg)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    div_d   = div_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LATCH;
      end
      LATCH: begin
        latch_d = bus.val_flat;
        div_d   = '0;
        dig_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // Dropping start wins over a simultaneous div wrap; dig is
        // restarted by the next LATCH anyway.
        if (!bus.start) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state values so the registered
  // outputs always describe the state/dig/div held in the same cycle.
  always_comb begin
    nib_d   = latch_d[int'(dig_d)*4 +: 4];
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    shown_d = 1'b0;
    if (state_d == SCAN) begin
      shown_d = 1'b1;
      seg_d   = hex_seg;
      // Decimal point marks the start of each value except the first.
      dp_d    = !((int'(dig_d) % DIG_PER_VAL == 0) && (dig_d != '0));
      // Last slot of each digit keeps all anodes off to avoid ghosting.
      if (div_d != DIV_LAST) an_d[dig_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      latch_q <= '0;
      div_q   <= '0;
      dig_q   <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      shown_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      shown_q <= shown_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.shown = shown_q;

endmodule
